// File: rtl/switch_pkg.sv
// Shared definitions for the 4-port switch: arbiter state encoding and header field widths.
package switch_pkg;

    localparam int NUM_PORTS = 4;

    // Packet header field widths.
    localparam int SRC_W  = 4;
    localparam int TGT_W  = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_XMIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request scanning ptr, ptr+1, ... mod 4.
module rr_priority_picker (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    // Scan from the farthest candidate down to ptr so the nearest set request wins.
    always_comb begin
        any = |req;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[2'(ptr + 2'(k))]) begin
                idx = 2'(ptr + 2'(k));
            end
        end
    end

endmodule

// File: rtl/switch_out_arbiter.sv
// Per-output-port round-robin arbiter: picks one input FIFO head targeting this port,
// drives the output mux select and the winning FIFO's pop (grant).
//
// Handshake toward the output: valid_out is high while the latched winner still
// requests in ARB_XMIT; a transfer happens in the cycle where valid_out and out_ready
// are both high, which is exactly the cycle grant pops the winner's FIFO. While
// out_ready is low, valid_out, mux_select and the winner are held stable.
module switch_out_arbiter
    import switch_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   head_valid,
    input  logic [4*NUM_PORTS-1:0] head_target,
    input  logic                   out_ready,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [1:0]             mux_select,
    output logic                   valid_out,
    output logic                   busy,
    output logic [CNT_W-1:0]       pkt_count,
    output logic                   arb_err,
    output arb_state_t             dbg_state,
    output logic [1:0]             dbg_rr_ptr
);

    arb_state_t           state, state_n;
    logic [1:0]           rr_ptr, rr_ptr_n;
    logic [1:0]           winner_q, winner_n;
    logic [CNT_W-1:0]     cnt_n;
    logic [NUM_PORTS-1:0] req;
    logic                 pick_any;
    logic [1:0]           pick_idx;

    // A head requests this port when valid and its target bit for PORT_ID is set.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i] = head_valid[i] & head_target[4*i+PORT_ID];
        end
    end

    // Target bits for the other output ports are consumed by their own arbiters.
    logic unused_target;
    assign unused_target = ^head_target;

    rr_priority_picker u_picker (
        .req (req),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // State, round-robin pointer, latched winner and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= 2'd0;
            winner_q  <= 2'd0;
            pkt_count <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            winner_q  <= winner_n;
            pkt_count <= cnt_n;
        end
    end

    // Next-state and outputs; grant/valid_out/arb_err are forced low during reset.
    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        winner_n  = winner_q;
        cnt_n     = pkt_count;
        grant     = '0;
        valid_out = 1'b0;
        arb_err   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) state_n = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (pick_any) begin
                    winner_n = pick_idx;
                    state_n  = ARB_XMIT;
                end else begin
                    state_n  = ARB_IDLE;
                end
            end
            ARB_XMIT: begin
                valid_out = req[winner_q];
                if (!req[winner_q]) begin
                    // Winner withdrew its request before being served.
                    arb_err = 1'b1;
                    state_n = ARB_IDLE;
                end else if (out_ready) begin
                    grant[winner_q] = 1'b1;
                    rr_ptr_n        = winner_q + 2'd1;
                    cnt_n           = pkt_count + CNT_W'(1);
                    state_n         = ARB_WAIT;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
        if (rst) begin
            grant     = '0;
            valid_out = 1'b0;
            arb_err   = 1'b0;
        end
    end

    assign mux_select = winner_q;
    assign busy       = (state != ARB_IDLE) && !rst;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed bench for switch_out_arbiter: two instances (PORT_ID 1 and 0) share the inputs.
module tb_switch_out_arbiter;
    import switch_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  head_valid;
    logic [15:0] head_target;
    logic        out_ready;

    logic [3:0]  grant1, grant0;
    logic [1:0]  mux1, mux0;
    logic        vld1, vld0, busy1, busy0, err1, err0;
    logic [15:0] pkt1, pkt0;
    arb_state_t  st1, st0;
    logic [1:0]  rr1, rr0;

    int chk_cnt = 0;
    int err_cnt = 0;

    switch_out_arbiter #(.PORT_ID(1), .NUM_PORTS(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_target(head_target),
        .out_ready(out_ready), .grant(grant1), .mux_select(mux1), .valid_out(vld1),
        .busy(busy1), .pkt_count(pkt1), .arb_err(err1), .dbg_state(st1), .dbg_rr_ptr(rr1)
    );

    switch_out_arbiter #(.PORT_ID(0), .NUM_PORTS(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_target(head_target),
        .out_ready(out_ready), .grant(grant0), .mux_select(mux0), .valid_out(vld0),
        .busy(busy0), .pkt_count(pkt0), .arb_err(err0), .dbg_state(st0), .dbg_rr_ptr(rr0)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled on the falling edge.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        head_valid = 4'b0000;
        out_ready  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        head_valid  = 4'b0000;
        head_target = 16'h0000;
        out_ready   = 1'b0;

        // Reset state
        tick();
        sample();
        check("rst_grant", 32'(grant1), 32'h0);
        check("rst_valid", 32'(vld1), 32'h0);
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_mux", 32'(mux1), 32'h0);
        check("rst_pkt", 32'(pkt1), 32'h0);
        check("rst_state", 32'(st1), 32'(ARB_IDLE));
        tick();
        rst = 1'b0;

        // Single requester: FIFO 2 targets port 1
        head_valid  = 4'b0100;
        head_target = 16'h0200;
        out_ready   = 1'b1;
        sample();
        check("t1_c0_state", 32'(st1), 32'(ARB_IDLE));
        tick();
        sample();
        check("t1_c1_state", 32'(st1), 32'(ARB_WAIT));
        check("t1_c1_grant", 32'(grant1), 32'h0);
        check("t1_c1_valid", 32'(vld1), 32'h0);
        check("t1_c1_busy", 32'(busy1), 32'h1);
        tick();
        sample();
        check("t1_c2_valid", 32'(vld1), 32'h1);
        check("t1_c2_mux", 32'(mux1), 32'h2);
        check("t1_c2_grant", 32'(grant1), 32'h4);
        tick();
        sample();
        check("t1_pkt", 32'(pkt1), 32'h1);
        check("t1_rr", 32'(rr1), 32'h3);
        check("t1_state", 32'(st1), 32'(ARB_WAIT));
        head_valid = 4'b0000;
        tick();
        sample();
        check("t1_idle", 32'(st1), 32'(ARB_IDLE));
        check("t1_dut0_pkt", 32'(pkt0), 32'h0);

        // Round robin: all four request continuously
        do_reset();
        head_valid  = 4'b1111;
        head_target = 16'h2222;
        out_ready   = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            sample();
            check("rr_wait_grant", 32'(grant1), 32'h0);
            tick();
            sample();
            check("rr_grant", 32'(grant1), 32'(4'b0001 << (k % 4)));
            check("rr_mux", 32'(mux1), 32'(k % 4));
            tick();
        end
        sample();
        check("rr_pkt", 32'(pkt1), 32'h5);

        // Backpressure with winner 2
        do_reset();
        head_valid = 4'b0100;
        out_ready  = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            sample();
            check("bp_valid", 32'(vld1), 32'h1);
            check("bp_mux", 32'(mux1), 32'h2);
            check("bp_grant", 32'(grant1), 32'h0);
            check("bp_state", 32'(st1), 32'(ARB_XMIT));
            tick();
        end
        out_ready = 1'b1;
        sample();
        check("bp_release_grant", 32'(grant1), 32'h4);
        tick();
        out_ready = 1'b0;
        sample();
        check("bp_after_grant", 32'(grant1), 32'h0);
        check("bp_after_state", 32'(st1), 32'(ARB_WAIT));
        check("bp_after_pkt", 32'(pkt1), 32'h1);
        check("bp_after_rr", 32'(rr1), 32'h3);

        // Withdrawal: winner 2 drops while others still request
        tick();
        head_valid = 4'b1011;
        sample();
        check("wd_err", 32'(err1), 32'h1);
        check("wd_grant", 32'(grant1), 32'h0);
        check("wd_valid", 32'(vld1), 32'h0);
        tick();
        sample();
        check("wd_state", 32'(st1), 32'(ARB_IDLE));
        check("wd_err_pulse", 32'(err1), 32'h0);
        check("wd_pkt", 32'(pkt1), 32'h1);
        check("wd_rr", 32'(rr1), 32'h3);

        // Reset in the middle of ARB_XMIT
        head_valid = 4'b0100;
        out_ready  = 1'b0;
        tick();
        tick();
        sample();
        check("mr_pre_state", 32'(st1), 32'(ARB_XMIT));
        rst       = 1'b1;
        out_ready = 1'b1;
        sample();
        check("mr_grant", 32'(grant1), 32'h0);
        check("mr_valid", 32'(vld1), 32'h0);
        check("mr_busy", 32'(busy1), 32'h0);
        tick();
        rst        = 1'b0;
        head_valid = 4'b0000;
        sample();
        check("mr_state", 32'(st1), 32'(ARB_IDLE));
        check("mr_pkt", 32'(pkt1), 32'h0);
        check("mr_mux", 32'(mux1), 32'h0);
        check("mr_rr", 32'(rr1), 32'h0);

        // Non-matching target for PORT_ID 0
        head_valid  = 4'b1111;
        head_target = 16'h8888;
        out_ready   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sample();
            check("nm_state", 32'(st0), 32'(ARB_IDLE));
            check("nm_busy", 32'(busy0), 32'h0);
            check("nm_grant", 32'(grant0), 32'h0);
            tick();
        end

        // FIFO 3 now targets port 0; only dut0 serves it
        head_target = 16'h1888;
        tick();
        tick();
        sample();
        check("p0_grant", 32'(grant0), 32'h8);
        check("p0_mux", 32'(mux0), 32'h3);
        check("p0_dut1_grant", 32'(grant1), 32'h0);
        tick();
        sample();
        check("p0_pkt", 32'(pkt0), 32'h1);
        check("p0_dut1_state", 32'(st1), 32'(ARB_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/switch_out_arbiter.md
Name: switch_out_arbiter

Overview:
- Per-output-port round-robin arbiter for the 4-port switch; one instance per output port.
- Watches the head-of-FIFO entries of all input ports and selects one whose header targets this port.
- Drives the output 4:1 mux select and the winning FIFO's read enable (grant), with a valid/ready handshake toward the output.
- Counts transmitted packets and flags requests withdrawn mid-grant.

Parameters:
- PORT_ID, 0, index of the output port this instance serves; selects bit PORT_ID of each 4-bit target field.
- NUM_PORTS, 4, number of input ports; fixed at 4, matching the 2-bit mux select.
- CNT_W, 16, width of pkt_count.

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- head_valid  input  NUM_PORTS  bit i: input FIFO i is non-empty.
- head_target  input  4*NUM_PORTS  bits [4i+3:4i]: one-hot target field of FIFO i's head packet.
- out_ready  input  1  downstream output can accept a packet this cycle.
- grant  output  NUM_PORTS  one-hot read enable to the winning FIFO; pops its head.
- mux_select  output  2  output mux select, equal to the winner index.
- valid_out  output  1  the packet on the mux output is valid.
- busy  output  1  high when the state is not ARB_IDLE.
- pkt_count  output  CNT_W  number of packets granted; wraps.
- arb_err  output  1  single-cycle pulse: the latched winner's request dropped during ARB_XMIT.

Behaviour:
- Request rule: req[i] = head_valid[i] & head_target[4i+PORT_ID]. Other target bits are ignored.
- Registered state: state, rr_ptr (2b), winner_q (2b), pkt_count.
- Reset values: state=ARB_IDLE, rr_ptr=0, winner_q=0, pkt_count=0.
- Reset cycle outputs: while rst=1, grant=0, valid_out=0, arb_err=0, busy=0, and mux_select=winner_q (0 after the first reset edge). Gate grant and valid_out combinationally with rst.
- FSM states:
  - ARB_IDLE: if req!=0, go to ARB_WAIT; otherwise stay.
  - ARB_WAIT: pick the winner, the first set req bit scanning rr_ptr, rr_ptr+1, … mod 4. Latch it into winner_q and go to ARB_XMIT. If req==0, go to ARB_IDLE. grant=0 and valid_out=0 in this state.
  - ARB_XMIT: mux_select=winner_q and valid_out=req[winner_q].
    - If req[winner_q]=0: arb_err=1 and go to ARB_IDLE. No grant; rr_ptr and pkt_count are unchanged.
    - Else if out_ready=1: grant[winner_q]=1 for exactly this cycle; rr_ptr <= winner_q+1 (mod 4, 2-bit wrap); pkt_count <= pkt_count+1 (wraps to 0); go to ARB_WAIT.
    - Else (backpressure): hold ARB_XMIT with grant=0; winner_q and mux_select stay stable.
- Latency and throughput:
  - Packet accepted no earlier than 2 cycles after req first seen in ARB_IDLE.
  - Sustained rate: 1 packet per 2 cycles (ARB_WAIT/ARB_XMIT alternating).
- Timing of outputs:
  - grant is combinational from state, req and out_ready.
  - mux_select is registered (winner_q).
- Fairness: a continuously requesting port waits at most 3 grants.
- Simultaneous events:
  - Requests changing during ARB_WAIT use that cycle's values.
  - New requests during ARB_XMIT do not preempt the latched winner.
- Invariant: grant is always zero or one-hot.

Decomposition:
- Shared package switch_pkg holds:
  - typedef arb_state_t {ARB_IDLE, ARB_WAIT, ARB_XMIT} (2-bit);
  - NUM_PORTS=4;
  - header field widths SRC_W=4, TGT_W=4, DATA_W=8.
- One combinational sub-module, rr_priority_picker: inputs req[4] and ptr[2]; outputs any and idx[2].

Test Plan:
- Single requester, PORT_ID=1, head_valid=4'b0100, head_target[11:8]=4'b0010, out_ready=1:
  - c1 ARB_WAIT;
  - c2 valid_out=1, mux_select=2, grant=4'b0100;
  - pkt_count=1 afterwards, rr_ptr=3.
- All four ports request continuously with a matching target, out_ready=1: grants in order 0,1,2,3,0 every 2 cycles; pkt_count=5 after 10 cycles in flow.
- Backpressure: out_ready=0 for 5 cycles in ARB_XMIT with winner 2:
  - valid_out=1, mux_select=2, grant=0 throughout;
  - out_ready=1 -> grant=4'b0100 that cycle only.
- Withdrawal: head_valid[winner] drops in ARB_XMIT -> arb_err pulses 1 cycle, grant=0, pkt_count and rr_ptr unchanged, next state ARB_IDLE.
- Reset mid-ARB_XMIT, rst=1 for 1 cycle:
  - grant=0 and valid_out=0 in that cycle;
  - afterwards state=ARB_IDLE, pkt_count=0, mux_select=0.
- Non-matching target, PORT_ID=0, all heads target 4'b1000 -> no request; stays in ARB_IDLE, busy=0, grant=0 for 20 cycles.
